// File: rtl/scrambler_cfg_pkg.sv
// rtl/scrambler_cfg_pkg.sv - shared scrambler config memory layout and writer state encoding
package scrambler_cfg_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam logic [7:0] COMMIT_MAGIC   = 8'hA5;
    localparam logic [5:0] MODE_ADDR      = 6'd0;
    localparam logic [5:0] SEED_BASE      = 6'd1;
    localparam int         SEED_BYTES     = 32;
    localparam logic [5:0] COMMIT_ADDR    = 6'd33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INVALIDATE,
        ST_RECV,
        ST_CHK,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/scrambler_config_writer_if.sv
// rtl/scrambler_config_writer_if.sv - byte stream in and config memory write port
interface scrambler_config_writer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] address;
    logic [7:0] data;
    logic       wren;

    modport master (
        output in_data, in_valid,
        input  in_ready, address, data, wren
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, address, data, wren
    );
endinterface

// File: rtl/scrambler_config_writer_timer.sv
// rtl/scrambler_config_writer_timer.sv - inter-byte idle timer (module cfg_timeout_timer)
module cfg_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count_q, count_d;

    // Fires on the last idle cycle so the FSM leaves exactly TIMEOUT_CYCLES clocks after the last byte.
    assign expired = enable && !clear && (count_q == W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/scrambler_config_writer.sv
// rtl/scrambler_config_writer.sv - framed byte stream to scrambler config memory writer
// Optional checksum byte and CHK state enabled by SCRAMBLER_WRITER_CHECKSUM_EN.
module scrambler_config_writer
    import scrambler_cfg_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] HEADER         = HEADER_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    scrambler_config_writer_if.slave  bus,
    output logic                      reset_n_scrambler,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam logic [5:0] LAST_ADDR = 6'(SEED_BASE + SEED_BYTES - 1);

    state_t     state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       wren_q, wren_d;
    logic       rst_scr_q, rst_scr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [5:0] cnt_q, cnt_d;
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
`endif

    logic accept;
    logic tmr_en;
    logic tmr_expired;

    assign accept = bus.in_valid && in_ready_q;
    assign tmr_en = (state_q == ST_RECV) || (state_q == ST_CHK);

    cfg_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept || !tmr_en),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        // Scrambler is released one cycle after the commit marker lands.
        rst_scr_d  = rst_scr_q | done_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        cnt_d      = cnt_q;
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && bus.in_data == HEADER) begin
                    state_d    = ST_INVALIDATE;
                    in_ready_d = 1'b0;
                    addr_d     = COMMIT_ADDR;
                    data_d     = 8'h00;
                    wren_d     = 1'b1;
                    rst_scr_d  = 1'b0;
                end
            end
            ST_INVALIDATE: begin
                state_d    = ST_RECV;
                in_ready_d = 1'b1;
                cnt_d      = MODE_ADDR;
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
                xor_d      = 8'h00;
`endif
            end
            ST_RECV: begin
                if (accept) begin
                    addr_d = cnt_q;
                    data_d = bus.in_data;
                    wren_d = 1'b1;
                    cnt_d  = cnt_q + 6'd1;
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
                    xor_d  = xor_q ^ bus.in_data;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_CHK;
                    end
`else
                    if (cnt_q == LAST_ADDR) begin
                        state_d    = ST_COMMIT;
                        in_ready_d = 1'b0;
                    end
`endif
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (bus.in_data == xor_q) begin
                        state_d    = ST_COMMIT;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
`endif
            ST_COMMIT: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                addr_d     = COMMIT_ADDR;
                data_d     = COMMIT_MAGIC;
                wren_d     = 1'b1;
                done_d     = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            addr_q     <= 6'd0;
            data_q     <= 8'h00;
            wren_q     <= 1'b0;
            rst_scr_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cnt_q      <= 6'd0;
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
            xor_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            rst_scr_q  <= rst_scr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cnt_q      <= cnt_d;
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.address       = addr_q;
    assign bus.data          = data_q;
    assign bus.wren          = wren_q;
    assign reset_n_scrambler = rst_scr_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
endmodule

// File: tb/tb_scrambler_config_writer.sv
// tb/tb_scrambler_config_writer.sv - directed self-checking bench for scrambler_config_writer
module tb_scrambler_config_writer;
    import scrambler_cfg_pkg::*;

    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rsc, busy, done, error;

    scrambler_config_writer_if bus();

    scrambler_config_writer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus               (bus),
        .reset_n_scrambler (rsc),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] mem [64];
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (bus.wren) begin
            mem[bus.address] = bus.data;
            wr_cnt++;
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("in_ready_bound", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic send_body();
        send(8'hA5);
        send(8'h01);
        send(8'h5A);
        repeat (31) send(8'h00);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({pfx, "_address"}, {26'd0, bus.address}, 32'd0);
        check({pfx, "_data"}, {24'd0, bus.data}, 32'd0);
        check({pfx, "_wren"}, {31'd0, bus.wren}, 32'd0);
        check({pfx, "_rsc"}, {31'd0, rsc}, 32'd1);
        check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        check({pfx, "_done"}, {31'd0, done}, 32'd0);
        check({pfx, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        int wr_base, done_base, err_base, k, nz;
        logic [7:0] garbage [3];
        garbage[0] = 8'h00;
        garbage[1] = 8'h13;
        garbage[2] = 8'hFF;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Garbage ahead of a header is dropped silently
        wr_base = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            send(garbage[i]);
            check("garbage_busy", {31'd0, busy}, 32'd0);
        end
        idle();
        @(negedge clk);
        check("garbage_wren", wr_cnt - wr_base, 0);

        // Full frame with exact cycle checks
        wr_base = wr_cnt; done_base = done_cnt; err_base = err_cnt;
        send(8'hA5);
        check("hdr_wren", {31'd0, bus.wren}, 32'd1);
        check("hdr_addr", {26'd0, bus.address}, 32'd33);
        check("hdr_data", {24'd0, bus.data}, 32'h00);
        check("hdr_rsc", {31'd0, rsc}, 32'd0);
        check("hdr_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("hdr_busy", {31'd0, busy}, 32'd1);
        send(8'h01);
        send(8'h5A);
        repeat (31) send(8'h00);
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
        check("chk_state_ready", {31'd0, bus.in_ready}, 32'd1);
        send(8'h5B);
        idle();
        check("chk_accept_wren", {31'd0, bus.wren}, 32'd0);
        check("chk_accept_ready", {31'd0, bus.in_ready}, 32'd0);
`else
        idle();
        check("last_wren", {31'd0, bus.wren}, 32'd1);
        check("last_addr", {26'd0, bus.address}, 32'd32);
        check("last_ready", {31'd0, bus.in_ready}, 32'd0);
`endif
        @(negedge clk);
        check("commit_wren", {31'd0, bus.wren}, 32'd1);
        check("commit_addr", {26'd0, bus.address}, 32'd33);
        check("commit_data", {24'd0, bus.data}, 32'hA5);
        check("commit_done", {31'd0, done}, 32'd1);
        check("commit_rsc", {31'd0, rsc}, 32'd0);
        @(negedge clk);
        check("release_rsc", {31'd0, rsc}, 32'd1);
        check("release_done", {31'd0, done}, 32'd0);
        check("release_busy", {31'd0, busy}, 32'd0);
        check("mem_mode", {24'd0, mem[0]}, 32'h01);
        check("mem_seed0", {24'd0, mem[1]}, 32'h5A);
        nz = 0;
        for (int a = 2; a <= 32; a++) if (mem[a] !== 8'h00) nz++;
        check("mem_seed_rest", nz, 0);
        check("mem_marker", {24'd0, mem[33]}, 32'hA5);
        check("frame_writes", wr_cnt - wr_base, 35);
        check("frame_done", done_cnt - done_base, 1);
        check("frame_err", err_cnt - err_base, 0);

`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
        // Bad checksum aborts without committing
        done_base = done_cnt; err_base = err_cnt;
        send_body();
        send(8'h00);
        idle();
        repeat (4) @(negedge clk);
        check("badcks_err", err_cnt - err_base, 1);
        check("badcks_done", done_cnt - done_base, 0);
        check("badcks_marker", {24'd0, mem[33]}, 32'h00);
        check("badcks_rsc", {31'd0, rsc}, 32'd0);
        check("badcks_busy", {31'd0, busy}, 32'd0);
`else
        // A trailing byte after commit lands in IDLE and is discarded
        wr_base = wr_cnt;
        send(8'h77);
        idle();
        @(negedge clk);
        check("trail_writes", wr_cnt - wr_base, 0);
        check("trail_busy", {31'd0, busy}, 32'd0);
`endif

        // Stall after 10 bytes until the timeout fires
        wr_base = wr_cnt; err_base = err_cnt;
        send(8'hA5);
        repeat (9) send(8'h11);
        idle();
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            k++;
            if (error) break;
        end
        check("timeout_cycles", k, TO);
        check("timeout_err", err_cnt - err_base, 1);
        @(negedge clk);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_ready", {31'd0, bus.in_ready}, 32'd1);
        check("timeout_marker", {24'd0, mem[33]}, 32'h00);
        check("timeout_rsc", {31'd0, rsc}, 32'd0);
        check("timeout_writes", wr_cnt - wr_base, 10);
        done_base = done_cnt;
        send_body();
`ifdef SCRAMBLER_WRITER_CHECKSUM_EN
        send(8'h5B);
`endif
        idle();
        repeat (4) @(negedge clk);
        check("recover_marker", {24'd0, mem[33]}, 32'hA5);
        check("recover_done", done_cnt - done_base, 1);
        check("recover_rsc", {31'd0, rsc}, 32'd1);

        // Asynchronous reset while seed byte 15 is on the bus
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 15; i++) send(8'(i + 1));
        bus.in_data = 8'h40;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_marker", {24'd0, mem[33]}, 32'h00);
        check("midrst_seed14", {24'd0, mem[15]}, 32'h0F);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scrambler_config_writer.md
# scrambler_config_writer

Writes the video-scrambler configuration (MODE byte plus 256-bit seed) into the 64x8 scrambler config memory from an incoming byte stream, e.g. a UART/host link. It is the write-side counterpart of the config reader: the reader fetches MODE and seed from the same memory layout this block produces. The block validates framing, optionally checks an XOR checksum, and holds the scrambler in reset while a new configuration is being written.

## Interface
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks between bytes inside a frame before the frame is aborted.
- HEADER, 8'hA5: frame start byte.
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- address  out  6  memory write address.
- data  out  8  memory write data.
- wren  out  1  memory write enable, one-cycle pulses.
- reset_n_scrambler  out  1  active-low scrambler hold.
- busy  out  1  frame in progress (any state except IDLE).
- done  out  1  one-cycle pulse on successful commit.
- error  out  1  one-cycle pulse on checksum mismatch or timeout.

## Operation
- Memory layout: addr 0 = MODE byte (bit 0 = MODE); addr 1..32 = seed bytes, addr 1 holds seed[7:0] and addr 32 holds seed[255:248]; addr 33 = commit marker, 8'hA5 when valid, 8'h00 when invalid.
- Frame: HEADER, MODE, seed byte 0 .. seed byte 31, then a checksum byte if SCRAMBLER_WRITER_CHECKSUM_EN is defined.
- States:
  - IDLE: in_ready=1; accepted bytes other than HEADER are discarded; HEADER -> INVALIDATE.
  - INVALIDATE: in_ready=0; write 8'h00 to addr 33; drive reset_n_scrambler low; clear cnt and xor_acc -> RECV.
  - RECV: in_ready=1; each accepted byte is written to addr cnt (0..32) and XORed into xor_acc. After the byte at cnt=32: -> CHK if the checksum is enabled, else -> COMMIT.
  - CHK: in_ready=1; accepted byte == xor_acc -> COMMIT; mismatch -> pulse error, go to IDLE.
  - COMMIT: in_ready=0; write 8'hA5 to addr 33; release reset_n_scrambler (high); pulse done -> IDLE.
- Timeout: a counter runs in RECV/CHK, is cleared on every accepted byte, and on reaching TIMEOUT_CYCLES pulses error and returns to IDLE.
- After an error, reset_n_scrambler stays low and the marker stays 8'h00 until a later frame commits.
- A HEADER byte received inside RECV is treated as data, not as a resync.

## Timing
- Reset values: state IDLE, in_ready 1, address 0, data 0, wren 0, reset_n_scrambler 1, busy 0, done 0, error 0.
- Write outputs are registered. A byte accepted in cycle N produces address/data/wren in cycle N+1, with wren high for exactly one cycle.
- HEADER accepted in cycle N: marker write in N+1, reset_n_scrambler low from N+1, in_ready 0 in N+1, in_ready 1 again in N+2.
- Last byte accepted in cycle N (without checksum): data write N+1, COMMIT marker write N+2 together with done, reset_n_scrambler high from N+3. The checksum variant adds the CHK byte before COMMIT.
- Back-to-back bytes (in_valid held high) are accepted every cycle in RECV, giving at most one write per cycle.
- Asynchronous reset mid-frame returns everything to reset values immediately. The memory keeps a partial image with marker 8'h00, and reset_n_scrambler goes to 1; the reader must treat a marker of 8'h00 as invalid.
- The timeout and a byte acceptance in the same cycle: the acceptance wins and the counter clears.

## Configuration
- SCRAMBLER_WRITER_CHECKSUM_EN defined: a 35-byte frame, with the checksum byte = XOR of MODE and all 32 seed bytes; the CHK state exists.
- Not defined: a 34-byte frame, the CHK state is removed, and COMMIT follows seed byte 31 directly. error then pulses only on timeout.

## Structure
- Package scrambler_cfg_pkg holds HEADER default, COMMIT_MAGIC 8'hA5, MODE_ADDR 0, SEED_BASE 1, SEED_BYTES 32, COMMIT_ADDR 33, and the state encoding. It is shared with the config reader.
- One sub-module, cfg_timeout_timer: clear/enable inputs, expired pulse output, width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Full frame A5, 01, 5A, then 31x00, then checksum 5B -> writes addr33=00, addr0=01, addr1=5A, addr2..32=00, addr33=A5; done one pulse; reset_n_scrambler low from the marker clear until the cycle after commit.
- Same frame with checksum 00 -> error pulse; addr33 remains 00; reset_n_scrambler stays low; no done.
- Garbage 00, 13, FF before A5 -> no wren, busy 0 until A5 is accepted.
- Stall mid-frame for TIMEOUT_CYCLES (TIMEOUT_CYCLES=100 in the bench) after 10 bytes -> error at cycle 100; IDLE; a subsequent full frame commits normally.
- Assert reset_n at seed byte 15 -> all outputs at reset values; addr33 remains 00.
- Built without SCRAMBLER_WRITER_CHECKSUM_EN: a 34-byte frame commits; an extra trailing byte is discarded in IDLE.
